ex_stage: RTL and testbench



---
 rtl/ex_stage.sv | 152 +++++++++++++++
 tb/tb_ex_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the RV32I pipeline: forwarding muxes, ALU, and branch/jump
// resolution, with everything registered into the EX/MEM pipeline register.
module ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rd,
   input  logic [2:0]      id_funct3,
   input  logic [3:0]      id_alu_control,
   input  logic            id_alu_src,
   input  logic            id_a_pc,
   input  logic            id_branch,
   input  logic            id_jal,
   input  logic            id_jalr,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_reg_write,
   input  logic            id_mem_to_reg,
   input  logic [1:0]      fwd_a,
   input  logic [1:0]      fwd_b,
   input  logic [XLEN-1:0] wb_data,
   input  logic            stall,
   input  logic            flush,
   output logic            mem_valid,
   output logic [XLEN-1:0] mem_alu_result,
   output logic [XLEN-1:0] mem_store_data,
   output logic [4:0]      mem_rd,
   output logic [2:0]      mem_funct3,
   output logic            mem_mem_read,
   output logic            mem_mem_write,
   output logic            mem_reg_write,
   output logic            mem_mem_to_reg,
   output logic            mem_redirect,
   output logic [XLEN-1:0] mem_redirect_pc
);

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_XOR  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SLTU = 4'b1010;
   localparam logic [3:0] ALU_SRL  = 4'b1011;
   localparam logic [3:0] ALU_SRA  = 4'b1100;

   logic [XLEN-1:0] a_fwd, b_fwd, op_a, op_b, alu_result;
   logic [XLEN-1:0] link_addr, target, result;
   logic [4:0]      shamt;
   logic            taken, redirect;

   // Forwarding reads mem_alu_result as currently held, so a stalled EX/MEM
   // register keeps feeding its value back.
   always_comb begin
      case (fwd_a)
         2'b01:   a_fwd = wb_data;
         2'b10:   a_fwd = mem_alu_result;
         default: a_fwd = id_rs1_data;
      endcase
      case (fwd_b)
         2'b01:   b_fwd = wb_data;
         2'b10:   b_fwd = mem_alu_result;
         default: b_fwd = id_rs2_data;
      endcase
   end

   assign op_a  = id_a_pc ? id_pc : a_fwd;
   assign op_b  = id_alu_src ? id_imm : b_fwd;
   assign shamt = op_b[4:0];

   always_comb begin
      alu_result = '0;
      case (id_alu_control)
         ALU_AND:  alu_result = op_a & op_b;
         ALU_OR:   alu_result = op_a | op_b;
         ALU_ADD:  alu_result = op_a + op_b;
         ALU_SUB:  alu_result = op_a - op_b;
         ALU_XOR:  alu_result = op_a ^ op_b;
         ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
         ALU_SLL:  alu_result = op_a << shamt;
         ALU_SRL:  alu_result = op_a >> shamt;
         ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
         default:  alu_result = '0;
      endcase
   end

   // Branch condition is read off the ALU output: SUB for EQ/NE, SLT/SLTU for the rest.
   always_comb begin
      taken = 1'b0;
      case (id_funct3)
         3'b000:  taken = (alu_result == '0);
         3'b001:  taken = (alu_result != '0);
         3'b100,
         3'b110:  taken = alu_result[0];
         3'b101,
         3'b111:  taken = ~alu_result[0];
         default: taken = 1'b0;
      endcase
   end

   assign link_addr = id_pc + XLEN'(4);
   assign target    = id_jalr ? ((a_fwd + id_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                              : (id_pc + id_imm);
   assign result    = (id_jal | id_jalr) ? link_addr : alu_result;
   assign redirect  = id_valid & ((id_branch & taken) | id_jal | id_jalr);

   // mem_valid marks a real instruction; stall holds the slot, flush turns it
   // into a bubble (controls cleared, data kept), and flush beats stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_valid       <= 1'b0;
         mem_alu_result  <= '0;
         mem_store_data  <= '0;
         mem_rd          <= '0;
         mem_funct3      <= '0;
         mem_mem_read    <= 1'b0;
         mem_mem_write   <= 1'b0;
         mem_reg_write   <= 1'b0;
         mem_mem_to_reg  <= 1'b0;
         mem_redirect    <= 1'b0;
         mem_redirect_pc <= '0;
      end else if (flush) begin
         mem_valid      <= 1'b0;
         mem_mem_read   <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_reg_write  <= 1'b0;
         mem_mem_to_reg <= 1'b0;
         mem_redirect   <= 1'b0;
      end else if (!stall) begin
         mem_valid       <= id_valid;
         mem_alu_result  <= result;
         mem_store_data  <= b_fwd;
         mem_rd          <= id_rd;
         mem_funct3      <= id_funct3;
         mem_mem_read    <= id_mem_read & id_valid;
         mem_mem_write   <= id_mem_write & id_valid;
         mem_reg_write   <= id_reg_write & id_valid;
         mem_mem_to_reg  <= id_mem_to_reg & id_valid;
         mem_redirect    <= redirect;
         mem_redirect_pc <= target;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: the driver pushes the expected EX/MEM contents
// for each cycle it drives, and a monitor pops and compares after every edge.
module tb_ex_stage;

   logic        clk, rst;
   logic        id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rd;
   logic [2:0]  id_funct3;
   logic [3:0]  id_alu_control;
   logic        id_alu_src, id_a_pc, id_branch, id_jal, id_jalr;
   logic        id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
   logic [1:0]  fwd_a, fwd_b;
   logic [31:0] wb_data;
   logic        stall, flush;
   logic        mem_valid;
   logic [31:0] mem_alu_result, mem_store_data, mem_redirect_pc;
   logic [4:0]  mem_rd;
   logic [2:0]  mem_funct3;
   logic        mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg, mem_redirect;

   ex_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rd(id_rd), .id_funct3(id_funct3), .id_alu_control(id_alu_control),
      .id_alu_src(id_alu_src), .id_a_pc(id_a_pc), .id_branch(id_branch),
      .id_jal(id_jal), .id_jalr(id_jalr), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
      .id_mem_to_reg(id_mem_to_reg), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .wb_data(wb_data), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
      .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_funct3(mem_funct3),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_redirect(mem_redirect), .mem_redirect_pc(mem_redirect_pc)
   );

   // ctl is {mem_read, mem_write, reg_write, mem_to_reg}
   typedef struct packed {
      logic        valid;
      logic [31:0] res;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [3:0]  ctl;
      logic        redir;
      logic [31:0] rpc;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_e;
   int   checks = 0;
   int   errors = 0;

   // clock/reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t mk(input logic v, input logic [31:0] res, input logic [31:0] sd,
                               input logic [4:0] rd, input logic [2:0] f3, input logic [3:0] ctl,
                               input logic redir, input logic [31:0] rpc);
      exp_t e;
      e.valid = v; e.res = res; e.sd = sd; e.rd = rd; e.f3 = f3;
      e.ctl = ctl; e.redir = redir; e.rpc = rpc;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // driver tasks
   task automatic clear_id();
      id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      id_rd = '0; id_funct3 = '0; id_alu_control = '0; id_alu_src = 1'b0; id_a_pc = 1'b0;
      id_branch = 1'b0; id_jal = 1'b0; id_jalr = 1'b0; id_mem_read = 1'b0;
      id_mem_write = 1'b0; id_reg_write = 1'b0; id_mem_to_reg = 1'b0;
      fwd_a = 2'b00; fwd_b = 2'b00; wb_data = '0; stall = 1'b0; flush = 1'b0; rst = 1'b0;
   endtask

   task automatic alu_op(input logic [3:0] code, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic src, input logic [4:0] rd);
      clear_id();
      id_valid = 1'b1; id_alu_control = code; id_rs1_data = rs1; id_rs2_data = rs2;
      id_imm = imm; id_alu_src = src; id_rd = rd; id_reg_write = 1'b1;
   endtask

   task automatic step(input exp_t e);
      exp_q.push_back(e);
      last_e = e;
      @(negedge clk);
   endtask

   // scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid",       {31'b0, mem_valid}, {31'b0, e.valid});
            chk("alu_result",  mem_alu_result, e.res);
            chk("store_data",  mem_store_data, e.sd);
            chk("rd",          {27'b0, mem_rd}, {27'b0, e.rd});
            chk("funct3",      {29'b0, mem_funct3}, {29'b0, e.f3});
            chk("ctl",         {28'b0, mem_mem_read, mem_mem_write, mem_reg_write, mem_mem_to_reg},
                               {28'b0, e.ctl});
            chk("redirect",    {31'b0, mem_redirect}, {31'b0, e.redir});
            chk("redirect_pc", mem_redirect_pc, e.rpc);
         end
      end
   end

   initial begin
      exp_t e;
      clear_id();
      rst = 1'b1;
      step(mk(0, 32'h0, 32'h0, 5'd0, 3'd0, 4'b0000, 0, 32'h0));

      // ADD/SUB wrap, shifts, compares, undefined code
      alu_op(4'b0010, 32'h7FFFFFFF, 32'h1, 32'h0, 0, 5'd1);
      step(mk(1, 32'h80000000, 32'h1, 5'd1, 3'd0, 4'b0010, 0, 32'h0));
      alu_op(4'b0110, 32'h0, 32'h1, 32'h0, 0, 5'd2);
      step(mk(1, 32'hFFFFFFFF, 32'h1, 5'd2, 3'd0, 4'b0010, 0, 32'h0));
      alu_op(4'b1100, 32'h80000000, 32'h0, 32'h4, 1, 5'd3);
      step(mk(1, 32'hF8000000, 32'h0, 5'd3, 3'd0, 4'b0010, 0, 32'h4));
      alu_op(4'b1011, 32'h80000000, 32'h0, 32'h4, 1, 5'd3);
      step(mk(1, 32'h08000000, 32'h0, 5'd3, 3'd0, 4'b0010, 0, 32'h4));
      alu_op(4'b0111, 32'h80000000, 32'h0, 32'h1, 1, 5'd3);
      step(mk(1, 32'h1, 32'h0, 5'd3, 3'd0, 4'b0010, 0, 32'h1));
      alu_op(4'b1010, 32'h80000000, 32'h0, 32'h1, 1, 5'd3);
      step(mk(1, 32'h0, 32'h0, 5'd3, 3'd0, 4'b0010, 0, 32'h1));
      alu_op(4'b0011, 32'h5, 32'h6, 32'h0, 0, 5'd4);
      step(mk(1, 32'h0, 32'h6, 5'd4, 3'd0, 4'b0010, 0, 32'h0));
      alu_op(4'b1000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 0, 5'd4);
      step(mk(1, 32'hF00FF00F, 32'h0F0F0F0F, 5'd4, 3'd0, 4'b0010, 0, 32'h0));
      alu_op(4'b1001, 32'h1, 32'h0, 32'h1F, 1, 5'd4);
      step(mk(1, 32'h80000000, 32'h0, 5'd4, 3'd0, 4'b0010, 0, 32'h1F));
      alu_op(4'b0000, 32'hF0F0, 32'hFF00, 32'h0, 0, 5'd4);
      step(mk(1, 32'hF000, 32'hFF00, 5'd4, 3'd0, 4'b0010, 0, 32'h0));

      // forwarding from EX/MEM and from writeback
      alu_op(4'b0010, 32'h8, 32'h0, 32'h8, 1, 5'd4);
      id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_funct3 = 3'b010;
      step(mk(1, 32'h10, 32'h0, 5'd4, 3'd2, 4'b1011, 0, 32'h8));
      alu_op(4'b0010, 32'h0, 32'h99, 32'h5, 1, 5'd6);
      fwd_a = 2'b10; fwd_b = 2'b01; wb_data = 32'h22;
      id_reg_write = 1'b0; id_mem_write = 1'b1; id_funct3 = 3'b010;
      step(mk(1, 32'h15, 32'h22, 5'd6, 3'd2, 4'b0100, 0, 32'h5));
      alu_op(4'b0001, 32'h1234, 32'h0F, 32'h0, 0, 5'd7);
      fwd_a = 2'b01; fwd_b = 2'b11; wb_data = 32'hF0;
      step(mk(1, 32'hFF, 32'h0F, 5'd7, 3'd0, 4'b0010, 0, 32'h0));

      // branches and jumps at pc=0x100
      alu_op(4'b0110, 32'h55, 32'h55, 32'h20, 0, 5'd0);
      id_reg_write = 1'b0; id_pc = 32'h100; id_branch = 1'b1; id_funct3 = 3'b000;
      step(mk(1, 32'h0, 32'h55, 5'd0, 3'd0, 4'b0000, 1, 32'h120));
      id_funct3 = 3'b001;
      step(mk(1, 32'h0, 32'h55, 5'd0, 3'd1, 4'b0000, 0, 32'h120));
      id_alu_control = 4'b0111; id_funct3 = 3'b100; id_rs1_data = 32'hFFFFFFFF; id_rs2_data = 32'h1;
      step(mk(1, 32'h1, 32'h1, 5'd0, 3'd4, 4'b0000, 1, 32'h120));
      id_alu_control = 4'b1010; id_funct3 = 3'b111; id_rs1_data = 32'h1; id_rs2_data = 32'hFFFFFFFF;
      step(mk(1, 32'h1, 32'hFFFFFFFF, 5'd0, 3'd7, 4'b0000, 0, 32'h120));
      alu_op(4'b0010, 32'h203, 32'h0, 32'h0, 1, 5'd5);
      id_pc = 32'h100; id_jalr = 1'b1;
      step(mk(1, 32'h104, 32'h0, 5'd5, 3'd0, 4'b0010, 1, 32'h202));
      alu_op(4'b0010, 32'h0, 32'h0, 32'h20, 1, 5'd1);
      id_pc = 32'h100; id_jal = 1'b1;
      step(mk(1, 32'h104, 32'h0, 5'd1, 3'd0, 4'b0010, 1, 32'h120));

      // stall, then stall+flush, then a redirecting bubble
      alu_op(4'b0010, 32'h3, 32'h4, 32'h0, 0, 5'd7);
      id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_funct3 = 3'b010;
      step(mk(1, 32'h7, 32'h4, 5'd7, 3'd2, 4'b1011, 0, 32'h0));
      for (int i = 0; i < 3; i++) begin
         alu_op(4'b0010, 32'h100 + i, 32'h9, 32'h40, 0, 5'd8);
         id_jal = 1'b1; stall = 1'b1;
         step(last_e);
      end
      stall = 1'b1; flush = 1'b1;
      e = last_e; e.valid = 1'b0; e.ctl = 4'b0000; e.redir = 1'b0;
      step(e);
      clear_id();
      id_jal = 1'b1; id_pc = 32'h200; id_imm = 32'h10; id_rs2_data = 32'h33;
      id_reg_write = 1'b1; id_rd = 5'd9; id_funct3 = 3'b001;
      step(mk(0, 32'h204, 32'h33, 5'd9, 3'd1, 4'b0000, 0, 32'h210));

      // reset while stalled
      alu_op(4'b0010, 32'h1, 32'h2, 32'h8, 0, 5'd3);
      id_jal = 1'b1; id_pc = 32'h300;
      step(mk(1, 32'h304, 32'h2, 5'd3, 3'd0, 4'b0010, 1, 32'h308));
      stall = 1'b1;
      step(last_e);
      rst = 1'b1;
      step(mk(0, 32'h0, 32'h0, 5'd0, 3'd0, 4'b0000, 0, 32'h0));
      clear_id();

      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
